div_iter: RTL and testbench
===========================

# div_iter

Iterative 32-bit integer divider in the EX stage. It accepts a divide request from EX and raises `stallreq_for_ex` toward the pipeline controller so the pipeline holds while the quotient and remainder are computed. It releases the stall in the same cycle the result is valid. It is the requesting end of the controller's EX stall protocol.

## Interface

Parameters:
- `WIDTH`, default 32: operand width; `result` is `2*WIDTH`.

Ports:
- `clk`  input  1  clock; all state updates on rising edge.
- `rst`  input  1  synchronous, active-low reset; sampled on rising edge of `clk`.
- `start`  input  1  divide request from EX; held high by EX until `ready` is seen.
- `signed_div`  input  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with `start` in DivFree.
- `op_a`  input  WIDTH  dividend; sampled in DivFree.
- `op_b`  input  WIDTH  divisor; sampled in DivFree.
- `annul`  input  1  cancel in-flight divide (exception or flush).
- `result`  output  2*WIDTH  {remainder, quotient}; valid only while `ready`=1.
- `ready`  output  1  result valid; high for exactly one cycle.
- `stallreq_for_ex`  output  1  stall request to the controller.

## Operation

- States: DivFree, DivByZero, DivOn, DivEnd.
- **DivFree**
  - `start`=1, `annul`=0, `op_b`=0: go to DivByZero.
  - `start`=1, `annul`=0, `op_b`≠0: latch operand magnitudes, sign flags and `signed_div`; clear the counter; go to DivOn.
- **DivByZero**
  - Quotient and remainder are forced to 0; go to DivEnd.
- **DivOn**
  - One restoring shift-subtract step per cycle on a `2*WIDTH+1`-bit working register.
  - When the counter reaches `WIDTH-1`, finish that step and go to DivEnd.
- **DivEnd**
  - `ready`=1 and `result` is driven.
  - Go to DivFree unconditionally on the next edge, whether or not `start` is high.
- **Signed mode**
  - Operands are negated to magnitude when negative.
  - The quotient is negated if the operand signs differ.
  - The remainder takes the sign of the dividend.
  - Arithmetic is modulo 2^WIDTH: 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0.
- **Stall request**
  - `stallreq_for_ex` = `start` & ~`annul` & (state ≠ DivEnd).
  - It is combinational, so the controller sees it in the same cycle `start` rises.
- **Annul**
  - `annul`=1 in any state returns to DivFree on the next edge.
  - `ready` stays 0 and `result` stays 0.
- **Reset** (`rst`=0 at an edge, including mid-division)
  - state = DivFree, counter = 0, working register = 0, `result` = 0, `ready` = 0.
  - `stallreq_for_ex` then follows its formula with state = DivFree.
- `result` holds 0 whenever `ready`=0.

## Timing

- The cycle in which `start` is first seen high in DivFree is T.
- Normal divide:
  - DivOn covers T+1..T+WIDTH.
  - DivEnd, with `ready`=1, is at T+WIDTH+1 (T+33 for WIDTH=32).
  - `stallreq_for_ex` is high T..T+WIDTH and low at T+WIDTH+1, so the pipeline advances at the end of the `ready` cycle.
- Divide by zero: DivByZero at T+1, DivEnd at T+2, stall high T..T+1.
- Back-to-back: a new `start` at T+WIDTH+2 is accepted with no bubble; the earliest next `ready` is at T+2·WIDTH+3.
- `annul` and a DivEnd transition in the same cycle: `ready` is still 1 that cycle, and the next state is DivFree.

## Configuration

- Macro: `DIV_SIGNED_EN`.
- Defined:
  - `signed_div` is honoured as described under Operation.
- Undefined:
  - `signed_div` is ignored and all divides are unsigned.
  - Sign and negation logic is removed.
  - The `signed_div` port remains, unconnected internally.

## Structure

- Shared defines header:
  - `StallBus`, `Stop`, `NoStop`.
  - Two-bit state encodings: DivFree=00, DivByZero=01, DivOn=10, DivEnd=11.
  - `DivResultReady` / `DivResultNotReady`.
- Single module with no sub-module.
- The shift-subtract step is inline, because the state machine and the datapath share the counter.

## Test plan

- **Unsigned divide:** `op_a`=100, `op_b`=7, unsigned, `start` held.
  - `ready` at T+33 with `result`={32'd2, 32'd14}.
  - `stallreq_for_ex` high T..T+32, low at T+33.
- **Signed divide:** `op_a`=0xFFFFFF9C (-100), `op_b`=7, signed.
  - Quotient 0xFFFFFFF2, remainder 0xFFFFFFFE, at T+33.
- **Divide by zero:** `op_a`=5, `op_b`=0.
  - `ready` at T+2 with `result`=0; stall high T..T+1 only.
- **Annul mid-division:** assert `annul` at T+10.
  - State is DivFree at T+11; `stallreq_for_ex` is 0 during the `annul` cycle.
  - `ready` never asserts; `result`=0.
- **Back-to-back:** 100/7 then 9/3, second `start` at T+34.
  - Second `ready` at T+67 with `result`={0, 3}.
- **Reset mid-division:** `rst`=0 at T+5 with `start` held.
  - At T+6: state DivFree, `ready`=0, `result`=0.
  - After `rst` returns to 1, the held `start` restarts the divide with fresh timing.

Source files
------------

// File: rtl/div_iter_pkg.sv
// Shared constants for the iterative divider: stall levels, FSM encodings and ready levels.
package div_iter_pkg;

  localparam int unsigned StallBus = 6;
  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;

  localparam logic [1:0] DivFree   = 2'b00;
  localparam logic [1:0] DivByZero = 2'b01;
  localparam logic [1:0] DivOn     = 2'b10;
  localparam logic [1:0] DivEnd    = 2'b11;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;

endpackage

// File: rtl/div_iter.sv
// Iterative restoring divider for the EX stage; stalls the pipeline until the result is ready.
// Signed division (DIV) is built only when DIV_SIGNED_EN is defined; otherwise all divides are unsigned.
module div_iter
  import div_iter_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_div,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  input  logic               annul,
  output logic [2*WIDTH-1:0] result,
  output logic               ready,
  output logic               stallreq_for_ex
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  logic [1:0]         state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [2*WIDTH:0]   work_q, work_d, step;
  logic [WIDTH-1:0]   divisor_q, divisor_d;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH-1:0]   quo, rem, quo_out, rem_out;
  logic [WIDTH:0]     top;
  logic               unused_work_msb;

`ifdef DIV_SIGNED_EN
  logic neg_a, neg_b;
  logic quo_neg_q, quo_neg_d, rem_neg_q, rem_neg_d;

  assign neg_a = signed_div & op_a[WIDTH-1];
  assign neg_b = signed_div & op_b[WIDTH-1];
  assign mag_a = neg_a ? -op_a : op_a;
  assign mag_b = neg_b ? -op_b : op_b;
`else
  logic unused_signed_div;

  assign unused_signed_div = signed_div;
  assign mag_a = op_a;
  assign mag_b = op_b;
`endif

  // One restoring step: shift left, subtract divisor from the upper half when it fits.
  always_comb begin
    step = {work_q[2*WIDTH-1:0], 1'b0};
    top  = step[2*WIDTH:WIDTH];
    if (top >= {1'b0, divisor_q}) begin
      step[2*WIDTH:WIDTH] = top - {1'b0, divisor_q};
      step[0]             = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    work_d    = work_q;
    divisor_d = divisor_q;
`ifdef DIV_SIGNED_EN
    quo_neg_d = quo_neg_q;
    rem_neg_d = rem_neg_q;
`endif
    case (state_q)
      DivFree: begin
        if (start && !annul) begin
          if (op_b == '0) begin
            state_d = DivByZero;
          end else begin
            work_d    = {{(WIDTH + 1){1'b0}}, mag_a};
            divisor_d = mag_b;
            cnt_d     = '0;
`ifdef DIV_SIGNED_EN
            quo_neg_d = neg_a ^ neg_b;
            rem_neg_d = neg_a;
`endif
            state_d   = DivOn;
          end
        end
      end
      DivByZero: begin
        work_d  = '0;
        cnt_d   = '0;
`ifdef DIV_SIGNED_EN
        quo_neg_d = 1'b0;
        rem_neg_d = 1'b0;
`endif
        state_d = DivEnd;
      end
      DivOn: begin
        work_d = step;
        cnt_d  = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          state_d = DivEnd;
        end
      end
      DivEnd:  state_d = DivFree;
      default: state_d = DivFree;
    endcase
    if (annul) begin
      state_d = DivFree;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= DivFree;
      cnt_q     <= '0;
      work_q    <= '0;
      divisor_q <= '0;
`ifdef DIV_SIGNED_EN
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      work_q    <= work_d;
      divisor_q <= divisor_d;
`ifdef DIV_SIGNED_EN
      quo_neg_q <= quo_neg_d;
      rem_neg_q <= rem_neg_d;
`endif
    end
  end

  // The MSB only holds the transient carry of a step; the final remainder fits in WIDTH bits.
  assign unused_work_msb = work_q[2*WIDTH];
  assign quo = work_q[WIDTH-1:0];
  assign rem = work_q[2*WIDTH-1:WIDTH];

`ifdef DIV_SIGNED_EN
  assign quo_out = quo_neg_q ? -quo : quo;
  assign rem_out = rem_neg_q ? -rem : rem;
`else
  assign quo_out = quo;
  assign rem_out = rem;
`endif

  assign ready  = (state_q == DivEnd) ? DivResultReady : DivResultNotReady;
  assign result = ready ? {rem_out, quo_out} : '0;

  assign stallreq_for_ex = (start && !annul && (state_q != DivEnd)) ? Stop : NoStop;

endmodule

// File: tb/tb_div_iter.sv
// Directed bench for div_iter: expected results queued at each request, checked when ready rises.
module tb_div_iter;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           start = 1'b0;
  logic           signed_div = 1'b0;
  logic           annul = 1'b0;
  logic [W-1:0]   op_a = '0;
  logic [W-1:0]   op_b = '0;
  logic [2*W-1:0] result;
  logic           ready;
  logic           stallreq_for_ex;

  int n_assert = 0;
  int n_fail   = 0;
  logic [2*W-1:0] sb[$];

  always #5 clk = ~clk;

  div_iter #(.WIDTH(W)) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .signed_div      (signed_div),
    .op_a            (op_a),
    .op_b            (op_b),
    .annul           (annul),
    .result          (result),
    .ready           (ready),
    .stallreq_for_ex (stallreq_for_ex)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference quotient/remainder built from the language's own / and % operators.
  function automatic logic [63:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic s);
    logic [W-1:0] ma, mb, q, r;
    logic na, nb;
    if (b == '0) return '0;
    na = 1'b0;
    nb = 1'b0;
`ifdef DIV_SIGNED_EN
    na = s & a[W-1];
    nb = s & b[W-1];
`else
    if (s) na = 1'b0;
`endif
    ma = na ? -a : a;
    mb = nb ? -b : b;
    q  = ma / mb;
    r  = ma % mb;
    if (na ^ nb) q = -q;
    if (na) r = -r;
    return {r, q};
  endfunction

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic go(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    op_a       = a;
    op_b       = b;
    signed_div = s;
    start      = 1'b1;
    #1;
  endtask

  // Called in cycle T with start held; expects ready exactly lat cycles later.
  task automatic run_check(input int lat, input string tag);
    bit seen = 1'b0;
    logic [63:0] e;
    for (int k = 0; k <= lat + 4; k++) begin
      if (k > 0) cyc();
      if (ready === 1'b1) begin
        seen = 1'b1;
        chk({tag, " latency"}, 64'(k), 64'(lat));
        chk({tag, " stall_at_ready"}, 64'(stallreq_for_ex), 64'd0);
        if (sb.size() == 0) begin
          n_assert++;
          n_fail++;
          $error("FAIL %s: observed ready with empty scoreboard, expected no ready", tag);
        end else begin
          e = sb.pop_front();
          chk({tag, " result"}, result, e);
        end
        break;
      end
      chk({tag, " stall_busy"}, 64'(stallreq_for_ex), 64'd1);
      chk({tag, " result_idle"}, result, 64'd0);
    end
    if (!seen) begin
      n_assert++;
      n_fail++;
      $error("FAIL %s timeout: observed no ready, expected ready at %0d", tag, lat);
    end
  endtask

  task automatic single(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input logic [63:0] exp, input int lat, input string tag);
    go(a, b, s);
    sb.push_back(exp);
    run_check(lat, tag);
    start = 1'b0;
    cyc();
    chk({tag, " ready_drop"}, 64'(ready), 64'd0);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic rs;

    // Reset state
    cyc();
    cyc();
    chk("reset ready", 64'(ready), 64'd0);
    chk("reset result", result, 64'd0);
    chk("reset stall", 64'(stallreq_for_ex), 64'd0);
    rst = 1'b1;
    start = 1'b1;
    annul = 1'b1;
    #1;
    chk("annul masks stall", 64'(stallreq_for_ex), 64'd0);
    start = 1'b0;
    annul = 1'b0;
    cyc();

    single(32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 33, "unsigned_100_7");
`ifdef DIV_SIGNED_EN
    single(32'hFFFFFF9C, 32'd7, 1'b1, {32'hFFFFFFFE, 32'hFFFFFFF2}, 33, "signed_m100_7");
    single(32'h80000000, 32'hFFFFFFFF, 1'b1, {32'h0, 32'h80000000}, 33, "signed_min_m1");
`else
    single(32'hFFFFFF9C, 32'd7, 1'b1, {32'd2, 32'h24924916}, 33, "signed_m100_7");
    single(32'h80000000, 32'hFFFFFFFF, 1'b1, {32'h80000000, 32'h0}, 33, "signed_min_m1");
`endif
    single(32'd5, 32'd0, 1'b0, 64'd0, 2, "div_by_zero");
    single(32'hFFFFFFFF, 32'd1, 1'b0, {32'd0, 32'hFFFFFFFF}, 33, "max_by_1");
    single(32'd3, 32'd9, 1'b0, {32'd3, 32'd0}, 33, "small_by_big");

    for (int i = 0; i < 3; i++) begin
      ra = $urandom;
      rb = $urandom_range(1, 32'hFFFF) << $urandom_range(0, 15);
      rs = 1'($urandom_range(0, 1));
      single(ra, rb, rs, model(ra, rb, rs), 33, "random");
    end

    // Back-to-back: second request accepted the cycle after ready
    go(32'd100, 32'd7, 1'b0);
    sb.push_back({32'd2, 32'd14});
    run_check(33, "b2b_first");
    op_a = 32'd9;
    op_b = 32'd3;
    sb.push_back({32'd0, 32'd3});
    cyc();
    run_check(33, "b2b_second");
    start = 1'b0;
    cyc();

    // Annul at T+10, then a fresh request at T+11 proves the FSM is back in DivFree
    go(32'd1000, 32'd3, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      cyc();
      if (i < 10) chk("annul pre stall", 64'(stallreq_for_ex), 64'd1);
    end
    annul = 1'b1;
    #1;
    chk("annul stall", 64'(stallreq_for_ex), 64'd0);
    chk("annul ready", 64'(ready), 64'd0);
    chk("annul result", result, 64'd0);
    cyc();
    annul = 1'b0;
    op_a  = 32'd9;
    op_b  = 32'd3;
    sb.push_back({32'd0, 32'd3});
    #1;
    run_check(33, "after_annul");
    start = 1'b0;
    cyc();

    // Reset at T+5 with start held; divide restarts from T+6
    go(32'd100, 32'd7, 1'b0);
    for (int i = 0; i < 5; i++) cyc();
    rst = 1'b0;
    cyc();
    chk("midreset ready", 64'(ready), 64'd0);
    chk("midreset result", result, 64'd0);
    chk("midreset stall", 64'(stallreq_for_ex), 64'd1);
    rst = 1'b1;
    sb.push_back({32'd2, 32'd14});
    #1;
    run_check(33, "after_reset");
    start = 1'b0;
    cyc();

    chk("scoreboard drained", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
